// File: rtl/rc4_mem_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : rc4_mem_decrypt
// Purpose  : RC4 PRGA stage; walks the S-box, XORs keystream with ROM bytes
//            and writes plaintext to RAM over one shared memory bus.
//            Optional: define MEM_DECRYPT_SWAP_SKIP_EN to skip no-op swaps.
// Revision : 1.0  initial release
// ============================================================================
module rc4_mem_decrypt (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_sig,
  input  logic [7:0] iterations,
  input  logic [7:0] q_data,
  output logic       finish,
  output logic       decrypt_mem_handler,
  output logic [7:0] address,
  output logic [7:0] data,
  output logic [1:0] memory_sel,
  output logic       wen
);

  localparam logic [1:0] C_SEL_S   = 2'd0;
  localparam logic [1:0] C_SEL_ENC = 2'd1;
  localparam logic [1:0] C_SEL_DEC = 2'd2;

  typedef enum logic [4:0] {
    IDLE, INC_I, WAIT_SI, READ_SI, ADDR_SJ, WAIT_SJ, READ_SJ, WR_J, WR_I,
    ADDR_F, WAIT_F, READ_F, ADDR_ENC, WAIT_ENC, READ_ENC, WR_DEC, NEXT, DONE
  } state_t;

  state_t     state_q, state_d;
  logic       go_q, go_d;
  logic [7:0] iter_q, iter_d;
  logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [7:0] si_q, si_d, sj_q, sj_d, f_q, f_d, e_q, e_d;
  logic [7:0] addr_q, addr_d, data_q, data_d;
  logic [1:0] sel_q, sel_d;
  logic       wen_q, wen_d, fin_q, fin_d, hnd_q, hnd_d;
  logic       swap_skip;

`ifdef MEM_DECRYPT_SWAP_SKIP_EN
  assign swap_skip = (i_q == j_q);
`else
  assign swap_skip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    go_d    = go_q;
    iter_d  = iter_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    si_d    = si_q;
    sj_d    = sj_q;
    f_d     = f_q;
    e_d     = e_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    wen_d   = 1'b0;
    fin_d   = 1'b0;

    // Transitions. A start is first registered (go_q) so the run begins
    // one cycle after the sampling edge.
    case (state_q)
      IDLE: begin
        if (go_q) begin
          go_d    = 1'b0;
          state_d = (iter_q == 8'd0) ? NEXT : INC_I;
        end else if (start_sig) begin
          go_d   = 1'b1;
          iter_d = iterations;
          i_d    = 8'd0;
          j_d    = 8'd0;
          k_d    = 8'd0;
        end
      end
      INC_I:    state_d = WAIT_SI;
      WAIT_SI:  state_d = READ_SI;
      READ_SI:  state_d = ADDR_SJ;
      ADDR_SJ:  state_d = WAIT_SJ;
      WAIT_SJ:  state_d = READ_SJ;
      READ_SJ:  state_d = swap_skip ? ADDR_F : WR_J;
      WR_J:     state_d = WR_I;
      WR_I:     state_d = ADDR_F;
      ADDR_F:   state_d = WAIT_F;
      WAIT_F:   state_d = READ_F;
      READ_F:   state_d = ADDR_ENC;
      ADDR_ENC: state_d = WAIT_ENC;
      WAIT_ENC: state_d = READ_ENC;
      READ_ENC: state_d = WR_DEC;
      WR_DEC: begin
        state_d = NEXT;
        k_d     = k_q + 8'd1;
      end
      NEXT:     state_d = (k_q == iter_q) ? DONE : INC_I;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Outputs are decoded from the state being entered so they register
    // alongside it; read captures happen on the edge that ends each WAIT.
    case (state_d)
      IDLE: begin
        addr_d = 8'd0;
        data_d = 8'd0;
        sel_d  = C_SEL_S;
      end
      INC_I: begin
        i_d    = i_q + 8'd1;
        addr_d = i_q + 8'd1;
        sel_d  = C_SEL_S;
      end
      READ_SI: si_d = q_data;
      ADDR_SJ: begin
        j_d    = j_q + si_q;
        addr_d = j_q + si_q;
        sel_d  = C_SEL_S;
      end
      READ_SJ: sj_d = q_data;
      WR_J: begin
        addr_d = j_q;
        data_d = si_q;
        sel_d  = C_SEL_S;
        wen_d  = 1'b1;
      end
      WR_I: begin
        addr_d = i_q;
        data_d = sj_q;
        sel_d  = C_SEL_S;
        wen_d  = 1'b1;
      end
      ADDR_F: begin
        addr_d = si_q + sj_q;
        sel_d  = C_SEL_S;
      end
      READ_F: f_d = q_data;
      ADDR_ENC: begin
        addr_d = k_q;
        sel_d  = C_SEL_ENC;
      end
      READ_ENC: e_d = q_data;
      WR_DEC: begin
        addr_d = k_q;
        data_d = f_q ^ e_q;
        sel_d  = C_SEL_DEC;
        wen_d  = 1'b1;
      end
      DONE:    fin_d = 1'b1;
      default: ;
    endcase

    hnd_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      go_q    <= 1'b0;
      iter_q  <= 8'd0;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      k_q     <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      f_q     <= 8'd0;
      e_q     <= 8'd0;
      addr_q  <= 8'd0;
      data_q  <= 8'd0;
      sel_q   <= 2'd0;
      wen_q   <= 1'b0;
      fin_q   <= 1'b0;
      hnd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      iter_q  <= iter_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      f_q     <= f_d;
      e_q     <= e_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      wen_q   <= wen_d;
      fin_q   <= fin_d;
      hnd_q   <= hnd_d;
    end
  end

  assign finish              = fin_q;
  assign decrypt_mem_handler = hnd_q;
  assign address             = addr_q;
  assign data                = data_q;
  assign memory_sel          = sel_q;
  assign wen                 = wen_q;

endmodule
`default_nettype wire

// File: tb/tb_rc4_mem_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc4_mem_decrypt
// Purpose  : Scoreboard bench for rc4_mem_decrypt with behavioural memories
//            and a software RC4 PRGA reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_rc4_mem_decrypt;

`ifdef MEM_DECRYPT_SWAP_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_sig = 1'b0;
  logic [7:0] iterations = 8'd0;
  logic [7:0] q_data = 8'd0;
  logic       finish, decrypt_mem_handler, wen;
  logic [7:0] address, data;
  logic [1:0] memory_sel;

  rc4_mem_decrypt dut (
    .clk                 (clk),
    .reset               (reset),
    .start_sig           (start_sig),
    .iterations          (iterations),
    .q_data              (q_data),
    .finish              (finish),
    .decrypt_mem_handler (decrypt_mem_handler),
    .address             (address),
    .data                (data),
    .memory_sel          (memory_sel),
    .wen                 (wen)
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem   [256];
  logic [7:0] rom     [256];
  logic [7:0] ram     [256];
  logic [7:0] exp_ram [256];
  wr_t        wq [$];

  int cyc     = 0;
  int hnd_lo  = 1;
  int hnd_hi  = 0;
  int fin_abs = -1;
  bit mon_en  = 1'b0;
  int n_chk   = 0;
  int n_pass  = 0;

  // Synchronous-read memories with one cycle of latency behind the bus mux.
  always @(posedge clk) begin
    cyc = cyc + 1;
    case (memory_sel)
      2'd0:    q_data <= s_mem[address];
      2'd1:    q_data <= rom[address];
      default: q_data <= ram[address];
    endcase
    if (wen) begin
      if (memory_sel == 2'd0)      s_mem[address] = data;
      else if (memory_sel == 2'd2) ram[address]   = data;
    end
  end

  function automatic void check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Reference PRGA on a copy of the current S memory; returns finish cycle.
  function automatic int build_expect(input int n);
    logic [7:0] s [256];
    logic [7:0] i, j, si, sj, fi;
    int cycles;
    wr_t w;
    wq.delete();
    for (int a = 0; a < 256; a++) s[a] = s_mem[a];
    i = 8'd0;
    j = 8'd0;
    cycles = 1;
    for (int k = 0; k < n; k++) begin
      i  = i + 8'd1;
      si = s[i];
      j  = j + si;
      sj = s[j];
      if (SKIP && i == j) begin
        cycles += 14;
      end else begin
        w.sel = 2'd0; w.addr = j; w.data = si; wq.push_back(w);
        w.sel = 2'd0; w.addr = i; w.data = sj; wq.push_back(w);
        cycles += 16;
      end
      s[j] = si;
      s[i] = sj;
      fi = si + sj;
      exp_ram[k] = s[fi] ^ rom[k];
      w.sel = 2'd2; w.addr = 8'(k); w.data = exp_ram[k]; wq.push_back(w);
    end
    return (n == 0) ? 2 : cycles;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      check("handler", int'(decrypt_mem_handler), int'(cyc >= hnd_lo && cyc <= hnd_hi));
      check("finish", int'(finish), int'(cyc == fin_abs));
      if (wen) begin
        if (wq.size() == 0) begin
          check("unexpected_wen", int'(wen), 0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          check("wr_sel",  int'(memory_sel), int'(w.sel));
          check("wr_addr", int'(address),    int'(w.addr));
          check("wr_data", int'(data),       int'(w.data));
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_finish"},  int'(finish), 0);
    check({tag, "_handler"}, int'(decrypt_mem_handler), 0);
    check({tag, "_address"}, int'(address), 0);
    check({tag, "_data"},    int'(data), 0);
    check({tag, "_sel"},     int'(memory_sel), 0);
    check({tag, "_wen"},     int'(wen), 0);
  endtask

  task automatic do_run(input int n, input bit hold);
    int f, s;
    @(posedge clk); #2;
    f = build_expect(n);
    iterations = 8'(n);
    start_sig  = 1'b1;
    s       = cyc + 1;
    hnd_lo  = s + 1;
    hnd_hi  = s + f;
    fin_abs = s + f;
    @(posedge clk); #2;
    iterations = 8'($urandom);
    if (!hold) start_sig = 1'b0;
    repeat (f + 1) @(posedge clk);
    #2;
    start_sig = 1'b0;
    check("writes_outstanding", wq.size(), 0);
    for (int k = 0; k < n; k++) check("ram_content", int'(ram[k]), int'(exp_ram[k]));
  endtask

  task automatic do_reset_run(input int n);
    int f, s;
    @(posedge clk); #2;
    f = build_expect(n);
    iterations = 8'(n);
    start_sig  = 1'b1;
    s       = cyc + 1;
    hnd_lo  = s + 1;
    hnd_hi  = s + f;
    fin_abs = s + f;
    @(posedge clk); #2;
    start_sig = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    reset   = 1'b1;
    hnd_hi  = cyc;
    fin_abs = -1;
    @(posedge clk); #2;
    reset = 1'b0;
    check_outputs_zero("abort");
    wq.delete();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      s_mem[a] = 8'd0; rom[a] = 8'd0; ram[a] = 8'd0; exp_ram[a] = 8'd0;
    end
    repeat (3) @(posedge clk);
    #2;
    check_outputs_zero("reset");
    reset  = 1'b0;
    mon_en = 1'b1;

    // Every memory reads back 0x01, one byte.
    for (int a = 0; a < 256; a++) begin s_mem[a] = 8'h01; rom[a] = 8'h01; end
    do_run(1, 1'b0);

    // Identity S-box, ROM counting 0..31.
    for (int a = 0; a < 256; a++) begin s_mem[a] = 8'(a); rom[a] = 8'(a); end
    do_run(32, 1'b0);

    do_run(0, 1'b0);

    repeat (6) begin
      for (int a = 0; a < 256; a++) begin
        s_mem[a] = 8'($urandom);
        rom[a]   = 8'($urandom);
      end
      do_run(int'($urandom_range(1, 24)), 1'b0);
    end

    // Small S values make i==j coincidences likely.
    for (int a = 0; a < 256; a++) s_mem[a] = 8'($urandom_range(0, 2));
    do_run(20, 1'b0);

    do_reset_run(10);
    do_run(5, 1'b0);

    do_run(4, 1'b1);
    repeat (20) @(posedge clk);
    #2;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
